nibble_serial_adder_seq: RTL
============================

Name: nibble_serial_adder_seq

Overview:
- Multi-cycle WIDTH-bit adder built around one shared 4-bit carry-lookahead slice.
- Sequences the slice over the operand nibbles, least significant nibble first, and carries the slice carry-out between cycles in a register.
- Input and output each use a valid/ready handshake.
- Used where area matters more than latency, e.g. accumulators and address adders in low-rate paths.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4; any other value is an elaboration error.
- NIB, WIDTH/4, derived number of slice iterations. Localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set presented
- in_ready  out  1  block can accept operands
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH+1  {carry_out, sum}
- busy  out  1  high in RUN or DONE

Behaviour:
- States and outputs:
  - States: IDLE, RUN, DONE (state register, 2 bits).
  - in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state!=IDLE).
  - All three are decoded from registered state only. No combinational path from any input to any output.
- Reset (async, rst=1):
  - state=IDLE, nibble index=0, carry=0, operand/sum registers=0.
  - Therefore out_valid=0, in_ready=1, busy=0, out_sum=0.
- IDLE:
  - On in_valid && in_ready at a clock edge: latch in_a, in_b; carry <= in_cin; idx <= 0; sum register <= 0; go to RUN.
  - in_valid low: stay in IDLE; registers hold.
- RUN, each cycle:
  - Slice inputs: A = a_reg[4*idx+3:4*idx], B = b_reg[4*idx+3:4*idx], cin = carry.
  - At the edge: sum_reg nibble idx <= slice sum[3:0]; carry <= slice sum[4]; idx <= idx+1.
  - When idx==NIB-1 at the edge: go to DONE and reset idx to 0.
  - idx never exceeds NIB-1 (no wrap past the last nibble).
- DONE:
  - out_sum = {carry, sum_reg}, held stable while out_valid=1 and out_ready=0.
  - On out_ready=1 at the edge: go to IDLE.
  - No new operands are accepted in the same cycle (in_ready is 0 in DONE).
- Latency and throughput:
  - Accept edge to out_valid high: exactly NIB cycles.
  - Minimum spacing between accepts: NIB+2 cycles (1 IDLE + NIB RUN + 1 DONE).
- Ignored inputs:
  - in_valid while busy has no effect; operand registers are not overwritten.
  - out_ready while not in DONE has no effect.
- Reset mid-operation:
  - Asserting rst in RUN or DONE discards the operation immediately.
  - Outputs return to reset values asynchronously.
  - The first accept is possible at the first clock edge after rst deasserts.
- Arithmetic:
  - Unsigned modulo-2^WIDTH sum plus carry-out.
  - out_sum equals in_a + in_b + in_cin exactly, as a (WIDTH+1)-bit value.
- Slice group G/P outputs are unused; left unconnected.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Nibble width constant NIB_W=4.
- One sub-module: the existing 4-bit carry-lookahead adder slice, instantiated once.
  - Combinational; 5-bit output {cout, sum}.
- Nibble select: an indexed part-select on a_reg/b_reg driven by idx, with idx width $clog2(NIB) (minimum 1).

Test Plan:
- WIDTH=16, accept A=0x1234, B=0x4321, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; out_sum=0x05555; in_ready returns high the following cycle.
- Carry ripple across all nibbles: A=0xFFFF, B=0x0000, cin=1 -> out_sum=0x10000. Also A=0xFFFF, B=0x0001, cin=0 -> out_sum=0x10000.
- Back-pressure: A=0x8000, B=0x8000, out_ready held 0 for 5 cycles -> out_valid stays 1 and out_sum stays 0x10000 throughout; returns to IDLE one edge after out_ready=1.
- Busy-ignore: accept A=0x0001, B=0x0002, then drive in_valid=1 with A=0xAAAA in every RUN cycle -> result 0x00003; in_ready=0 during RUN/DONE; the second operand set is accepted only after returning to IDLE.
- Reset mid-RUN: assert rst during the 2nd RUN cycle -> out_valid=0, in_ready=1, busy=0 immediately. Next operation A=0x00FF, B=0x0001 -> out_sum=0x00100 (no stale carry).
- Random: 1000 random A/B/cin with random out_ready stalls, WIDTH=16 and WIDTH=8 -> every out_sum matches the reference a+b+cin; latency always equals NIB.

Source files
------------

// File: rtl/nibble_serial_adder_seq_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding and slice width.
package nibble_serial_adder_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_seq_cla4.sv
// 4-bit carry-lookahead adder slice; purely combinational, {cout, sum} plus group G/P.
module nibble_serial_adder_seq_cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [4:0] sum_o,
    output logic       grp_g_o,
    output logic       grp_p_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is expanded from the slice carry-in; no ripple inside the slice.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum_o   = {c[4], p ^ c[3:0]};
    assign grp_g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p_o = &p;

endmodule

// File: rtl/nibble_serial_adder_seq.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit CLA slice stepped over the operand
// nibbles LSB first, with the slice carry held in a register between cycles.
module nibble_serial_adder_seq
    import nibble_serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
            $error("nibble_serial_adder_seq: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;

    logic [IDX_W+1:0]   nib_lsb;
    logic [NIB_W-1:0]   slice_a;
    logic [NIB_W-1:0]   slice_b;
    logic [NIB_W:0]     slice_sum;

    assign nib_lsb = {idx_q, 2'b00};
    assign slice_a = a_q[nib_lsb +: NIB_W];
    assign slice_b = b_q[nib_lsb +: NIB_W];

    nibble_serial_adder_seq_cla4 u_slice (
        .a_i     (slice_a),
        .b_i     (slice_b),
        .cin_i   (carry_q),
        .sum_o   (slice_sum),
        .grp_g_o (),
        .grp_p_o ()
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[nib_lsb +: NIB_W] = slice_sum[NIB_W-1:0];
                carry_d                 = slice_sum[NIB_W];
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // Handshake flags come from the state register alone, so no input reaches an output.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = {carry_q, sum_q};

endmodule
